// File: rtl/jump_physics_pkg.sv
// Shared types and default constants for the jump_physics vertical-motion engine.
// Position and velocity are fixed point with FRAC fractional bits (units of 1/16 px).
// Contents:
//   state_t       GROUND / RISE / FALL encodings
//   Y_W, FRAC,    pixel width, fraction width,
//   V_W, P_W,     velocity width, position register width,
//   S_W           wide signed width for the position sum
//   *_DEF         default motion constants in Q.FRAC
//   to_fixed()    pixel row -> Q.FRAC position
package jump_physics_pkg;

  localparam int Y_W  = 32'sd11;
  localparam int FRAC = 32'sd4;
  localparam int V_W  = 32'sd12;
  localparam int P_W  = Y_W + FRAC;
  // Two extra bits: one for the sign, one for headroom so pos + vel never wraps.
  localparam int S_W  = P_W + 32'sd2;

  localparam logic signed [V_W-1:0] GRAVITY_DEF = 12'sd8;
  localparam logic signed [V_W-1:0] FAST_G_DEF  = 12'sd32;
  localparam logic signed [V_W-1:0] V0_DEF      = -12'sd96;
  localparam logic signed [V_W-1:0] V_CUT_DEF   = -12'sd32;
  localparam logic signed [V_W-1:0] V_MAX_DEF   = 12'sd128;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  function automatic logic [P_W-1:0] to_fixed(input logic [Y_W-1:0] y);
    return {y, {FRAC{1'b0}}};
  endfunction

endpackage

// File: rtl/jump_physics_if.sv
// Control/render bundle for jump_physics.
// master: drives tick, ground_y, jump_req, fast_fall; observes the motion outputs.
// slave : the physics engine (receives controls, drives jump_ack, land, airborne,
//         state, y_pos, vel).
interface jump_physics_if;
  import jump_physics_pkg::*;

  logic                  tick;
  logic [Y_W-1:0]        ground_y;
  logic                  jump_req;
  logic                  fast_fall;
  logic                  jump_ack;
  logic                  land;
  logic                  airborne;
  state_t                state;
  logic [Y_W-1:0]        y_pos;
  logic signed [V_W-1:0] vel;

  modport master (
    output tick, ground_y, jump_req, fast_fall,
    input  jump_ack, land, airborne, state, y_pos, vel
  );

  modport slave (
    input  tick, ground_y, jump_req, fast_fall,
    output jump_ack, land, airborne, state, y_pos, vel
  );

endinterface

// File: rtl/jump_physics_velocity_integrator.sv
// Combinational velocity update for one frame tick.
// Ports:
//   i_vel        current signed velocity (Q.FRAC)
//   i_fast_fall  selects FAST_G instead of GRAVITY
//   i_jump_req   jump button level
//   i_rising     engine is in RISE (short-hop cap only applies there)
//   o_vel_next   vel + g, saturated to [min, V_MAX], then short-hop capped
//   o_apex       o_vel_next >= 0 (upward motion has ended)
module velocity_integrator
  import jump_physics_pkg::*;
#(
  parameter logic signed [V_W-1:0] GRAVITY = GRAVITY_DEF,
  parameter logic signed [V_W-1:0] FAST_G  = FAST_G_DEF,
  parameter logic signed [V_W-1:0] V_CUT   = V_CUT_DEF,
  parameter logic signed [V_W-1:0] V_MAX   = V_MAX_DEF
) (
  input  logic                  i_fast_fall,
  input  logic                  i_jump_req,
  input  logic                  i_rising,
  input  logic signed [V_W-1:0] i_vel,
  output logic signed [V_W-1:0] o_vel_next,
  output logic                  o_apex
);

  localparam logic signed [V_W:0] VMAX_X = {V_MAX[V_W-1], V_MAX};
  localparam logic signed [V_W:0] VMIN_X = {2'b11, {(V_W-1){1'b0}}};

  logic signed [V_W-1:0] w_g;
  logic signed [V_W:0]   w_sum;
  logic signed [V_W-1:0] w_sat;

  // Gravity add in one extra bit, clamp to the representable/terminal range, then apply the
  // early-release cap that turns a held jump into a short hop.
  always_comb begin
    w_g   = i_fast_fall ? FAST_G : GRAVITY;
    w_sum = {i_vel[V_W-1], i_vel} + {w_g[V_W-1], w_g};
    if (w_sum > VMAX_X) begin
      w_sat = V_MAX;
    end else if (w_sum < VMIN_X) begin
      w_sat = VMIN_X[V_W-1:0];
    end else begin
      w_sat = w_sum[V_W-1:0];
    end
    if (i_rising && !i_jump_req && (w_sat < V_CUT)) begin
      o_vel_next = V_CUT;
    end else begin
      o_vel_next = w_sat;
    end
    o_apex = ~o_vel_next[V_W-1];
  end

endmodule

// File: rtl/jump_physics.sv
// Fixed-point vertical-motion engine for the player sprite: GROUND/RISE/FALL FSM that integrates
// position and velocity once per frame tick, with short hop, fast-fall, terminal velocity,
// ceiling clamp and a one-cycle landing strobe. All outputs are registered.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset (aborts any jump straight to GROUND, no land pulse)
//   bus  jump_physics_if.slave: tick, ground_y, jump_req, fast_fall in;
//        jump_ack, land, airborne, state, y_pos, vel out
module jump_physics
  import jump_physics_pkg::*;
#(
  parameter logic signed [V_W-1:0] GRAVITY = GRAVITY_DEF,
  parameter logic signed [V_W-1:0] FAST_G  = FAST_G_DEF,
  parameter logic signed [V_W-1:0] V0      = V0_DEF,
  parameter logic signed [V_W-1:0] V_CUT   = V_CUT_DEF,
  parameter logic signed [V_W-1:0] V_MAX   = V_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  jump_physics_if.slave bus
);

  state_t                r_state, w_state_next;
  logic [P_W-1:0]        r_pos, w_pos_next;
  logic signed [V_W-1:0] r_vel, w_vel_next;
  logic                  r_ack, w_ack_next;
  logic                  r_land, w_land_next;
  logic                  r_airborne;

  logic [P_W-1:0]        w_ground_fx;
  logic signed [S_W-1:0] w_ground_cmp;
  logic signed [S_W-1:0] w_vel_sx;
  logic signed [S_W-1:0] w_p_sum;
  logic signed [V_W-1:0] w_v_int;
  logic                  w_apex;

  assign w_ground_fx  = to_fixed(bus.ground_y);
  assign w_ground_cmp = $signed({2'b00, w_ground_fx});
  assign w_vel_sx     = {{(S_W-V_W){r_vel[V_W-1]}}, r_vel};
  // Wide signed sum so an overshoot above the top of the screen shows up as negative.
  assign w_p_sum      = $signed({2'b00, r_pos}) + w_vel_sx;

  velocity_integrator #(
    .GRAVITY (GRAVITY),
    .FAST_G  (FAST_G),
    .V_CUT   (V_CUT),
    .V_MAX   (V_MAX)
  ) u_vel (
    .i_fast_fall (bus.fast_fall),
    .i_jump_req  (bus.jump_req),
    .i_rising    (r_state == ST_RISE),
    .i_vel       (r_vel),
    .o_vel_next  (w_v_int),
    .o_apex      (w_apex)
  );

  // Next-state and next-register values for the motion FSM.
  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_vel_next   = r_vel;
    w_ack_next   = 1'b0;
    w_land_next  = 1'b0;
    case (r_state)
      ST_GROUND: begin
        // Standing: follow the ground line every cycle, launch only on a tick.
        w_pos_next = w_ground_fx;
        w_vel_next = {V_W{1'b0}};
        if (bus.tick && bus.jump_req) begin
          w_vel_next   = V0;
          w_state_next = ST_RISE;
          w_ack_next   = 1'b1;
        end else begin
          w_state_next = ST_GROUND;
        end
      end
      ST_RISE, ST_FALL: begin
        if (bus.tick) begin
          // Landing wins over the ceiling clamp.
          if (w_p_sum >= w_ground_cmp) begin
            w_pos_next   = w_ground_fx;
            w_vel_next   = {V_W{1'b0}};
            w_state_next = ST_GROUND;
            w_land_next  = 1'b1;
          end else if (w_p_sum[S_W-1]) begin
            w_pos_next   = {P_W{1'b0}};
            w_vel_next   = {V_W{1'b0}};
            w_state_next = ST_FALL;
          end else begin
            w_pos_next   = w_p_sum[P_W-1:0];
            w_vel_next   = w_v_int;
            w_state_next = w_apex ? ST_FALL : r_state;
          end
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = ST_GROUND;
        w_pos_next   = w_ground_fx;
        w_vel_next   = {V_W{1'b0}};
      end
    endcase
  end

  // State, position, velocity and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_GROUND;
      r_pos      <= w_ground_fx;
      r_vel      <= {V_W{1'b0}};
      r_ack      <= 1'b0;
      r_land     <= 1'b0;
      r_airborne <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pos      <= w_pos_next;
      r_vel      <= w_vel_next;
      r_ack      <= w_ack_next;
      r_land     <= w_land_next;
      r_airborne <= (w_state_next != ST_GROUND);
    end
  end

  assign bus.jump_ack = r_ack;
  assign bus.land     = r_land;
  assign bus.airborne = r_airborne;
  assign bus.state    = r_state;
  assign bus.y_pos    = r_pos[P_W-1:FRAC];
  assign bus.vel      = r_vel;

endmodule

// File: tb/tb_jump_physics.sv
// Self-checking bench for jump_physics: a scoreboard queue of expected outputs fed either from a
// hand-written vector table or from an integer behavioural model, plus fixed checkpoints.
module tb_jump_physics;

  typedef struct packed {
    logic        rst;
    logic        tick;
    logic        jq;
    logic        ff;
    logic [10:0] gy;
  } in_t;

  typedef struct packed {
    logic [1:0]        st;
    logic [10:0]       y;
    logic signed [11:0] v;
    logic              ack;
    logic              land;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t e;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  int m_st, m_pos, m_vel;
  bit m_ack, m_land;

  jump_physics_if bus();

  jump_physics u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour in plain integers.
  task automatic model_step(input in_t in, output exp_t e);
    int p, v;
    m_ack  = 1'b0;
    m_land = 1'b0;
    if (in.rst) begin
      m_st = 0; m_pos = int'(in.gy) * 16; m_vel = 0;
    end else if (m_st == 0) begin
      m_pos = int'(in.gy) * 16; m_vel = 0;
      if (in.tick && in.jq) begin
        m_vel = -96; m_st = 1; m_ack = 1'b1;
      end
    end else if (in.tick) begin
      p = m_pos + m_vel;
      v = m_vel + (in.ff ? 32 : 8);
      if (v > 128) v = 128;
      if (m_st == 1 && !in.jq && v < -32) v = -32;
      if (p >= int'(in.gy) * 16) begin
        m_pos = int'(in.gy) * 16; m_vel = 0; m_st = 0; m_land = 1'b1;
      end else if (p < 0) begin
        m_pos = 0; m_vel = 0; m_st = 2;
      end else begin
        m_pos = p; m_vel = v;
        if (v >= 0) m_st = 2;
      end
    end
    e.st   = 2'(m_st);
    e.y    = 11'(m_pos / 16);
    e.v    = 12'(m_vel);
    e.ack  = m_ack;
    e.land = m_land;
  endtask

  // Drive one cycle of inputs (called at negedge), then compare after the edge.
  task automatic drive(input in_t in, input exp_t e);
    exp_t ee;
    rst          = in.rst;
    bus.tick     = in.tick;
    bus.jump_req = in.jq;
    bus.fast_fall = in.ff;
    bus.ground_y = in.gy;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ee = exp_q.pop_front();
    check("state", int'(bus.state), int'(ee.st));
    check("y_pos", int'(bus.y_pos), int'(ee.y));
    check("vel", int'(bus.vel), int'(ee.v));
    check("jump_ack", int'(bus.jump_ack), int'(ee.ack));
    check("land", int'(bus.land), int'(ee.land));
    check("airborne", int'(bus.airborne), (ee.st != 2'd0) ? 1 : 0);
  endtask

  task automatic step_model(input in_t in);
    exp_t e;
    model_step(in, e);
    drive(in, e);
  endtask

  initial begin
    vec_t vecs[14];
    exp_t dummy;
    int   tv[5];
    tv = '{32, 64, 96, 128, 128};

    // Short hop, airborne jump_req ignored, reset in FALL path, reset mid-RISE.
    vecs[0]  = '{'{1'b0, 1'b1, 1'b1, 1'b0, 11'd200}, '{2'd1, 11'd200, -12'sd96, 1'b1, 1'b0}};
    vecs[1]  = '{'{1'b0, 1'b0, 1'b0, 1'b0, 11'd200}, '{2'd1, 11'd200, -12'sd96, 1'b0, 1'b0}};
    vecs[2]  = '{'{1'b0, 1'b1, 1'b0, 1'b0, 11'd200}, '{2'd1, 11'd194, -12'sd32, 1'b0, 1'b0}};
    vecs[3]  = '{'{1'b0, 1'b0, 1'b0, 1'b0, 11'd200}, '{2'd1, 11'd194, -12'sd32, 1'b0, 1'b0}};
    vecs[4]  = '{'{1'b0, 1'b1, 1'b0, 1'b0, 11'd200}, '{2'd1, 11'd192, -12'sd24, 1'b0, 1'b0}};
    vecs[5]  = '{'{1'b0, 1'b1, 1'b0, 1'b0, 11'd200}, '{2'd1, 11'd190, -12'sd16, 1'b0, 1'b0}};
    vecs[6]  = '{'{1'b0, 1'b1, 1'b0, 1'b0, 11'd200}, '{2'd1, 11'd189, -12'sd8,  1'b0, 1'b0}};
    vecs[7]  = '{'{1'b0, 1'b1, 1'b0, 1'b0, 11'd200}, '{2'd2, 11'd189, 12'sd0,   1'b0, 1'b0}};
    vecs[8]  = '{'{1'b0, 1'b1, 1'b1, 1'b0, 11'd200}, '{2'd2, 11'd189, 12'sd8,   1'b0, 1'b0}};
    vecs[9]  = '{'{1'b1, 1'b0, 1'b0, 1'b0, 11'd200}, '{2'd0, 11'd200, 12'sd0,   1'b0, 1'b0}};
    vecs[10] = '{'{1'b0, 1'b1, 1'b1, 1'b0, 11'd200}, '{2'd1, 11'd200, -12'sd96, 1'b1, 1'b0}};
    vecs[11] = '{'{1'b0, 1'b1, 1'b1, 1'b0, 11'd200}, '{2'd1, 11'd194, -12'sd88, 1'b0, 1'b0}};
    vecs[12] = '{'{1'b1, 1'b1, 1'b1, 1'b0, 11'd200}, '{2'd0, 11'd200, 12'sd0,   1'b0, 1'b0}};
    vecs[13] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 11'd200}, '{2'd0, 11'd200, 12'sd0,   1'b0, 1'b0}};

    rst = 1'b1;
    bus.tick = 1'b0; bus.jump_req = 1'b0; bus.fast_fall = 1'b0; bus.ground_y = 11'd200;
    m_st = 0; m_pos = 0; m_vel = 0; m_ack = 1'b0; m_land = 1'b0;
    @(negedge clk);

    // Reset state, then ground tracking with a one-cycle lag.
    step_model('{1'b1, 1'b0, 1'b0, 1'b0, 11'd200});
    step_model('{1'b1, 1'b0, 1'b1, 1'b0, 11'd200});
    check("reset_y", int'(bus.y_pos), 200);
    step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd200});
    step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd180});
    check("track_y", int'(bus.y_pos), 180);
    step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd200});

    // Table vectors; the model is stepped too so later sequences start in sync.
    for (int i = 0; i < 14; i++) begin
      model_step(vecs[i].in, dummy);
      drive(vecs[i].in, vecs[i].e);
    end

    // Full jump with jump_req held through landing: no ack on the landing tick, ack on the next.
    for (int k = 0; k <= 26; k++) begin
      step_model('{1'b0, 1'b1, 1'b1, 1'b0, 11'd200});
      if (k == 0)  check("full_ack0", int'(bus.jump_ack), 1);
      if (k == 1)  check("full_y1", int'(bus.y_pos), 194);
      if (k == 12) begin
        check("full_apex_y", int'(bus.y_pos), 161);
        check("full_apex_state", int'(bus.state), 2);
      end
      if (k == 25) begin
        check("full_land", int'(bus.land), 1);
        check("full_land_y", int'(bus.y_pos), 200);
        check("full_land_noack", int'(bus.jump_ack), 0);
      end
      if (k == 26) check("rejump_ack", int'(bus.jump_ack), 1);
      step_model('{1'b0, 1'b0, 1'b1, 1'b0, 11'd200});
    end

    // Terminal velocity: the jump accepted above continues; fast-fall from the apex.
    for (int k = 1; k <= 20; k++) begin
      step_model('{1'b0, 1'b1, (k <= 12), (k >= 13), 11'd200});
      if (k >= 13 && k <= 17) check("term_vel", int'(bus.vel), tv[k-13]);
      if (int'(bus.vel) > 128) check("vmax", int'(bus.vel), 128);
      if (k == 20) check("term_land", int'(bus.land), 1);
      step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd200});
    end

    // Ceiling clamp with a low ground line, then landing at 20.
    step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd20});
    step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd20});
    check("ceil_ground_y", int'(bus.y_pos), 20);
    for (int k = 0; k <= 14; k++) begin
      step_model('{1'b0, 1'b1, 1'b1, 1'b0, 11'd20});
      if (k == 3) check("ceil_y3", int'(bus.y_pos), 3);
      if (k == 4) begin
        check("ceil_y", int'(bus.y_pos), 0);
        check("ceil_vel", int'(bus.vel), 0);
        check("ceil_state", int'(bus.state), 2);
      end
      if (k == 14) begin
        check("ceil_land", int'(bus.land), 1);
        check("ceil_land_y", int'(bus.y_pos), 20);
      end
      step_model('{1'b0, 1'b0, 1'b0, 1'b0, 11'd20});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
